hazard_stall_ctrl: RTL and testbench
====================================

# hazard_stall_ctrl

Pipeline hazard and stall controller for the five-stage MIPS core. Watches the instructions held in the D, E and M stages and produces hold/clear controls for the PC, IF/ID and ID/EX registers. Covers three cases: load-use hazards, branch/jr operand hazards (branches resolve in D), and the multi-cycle mult/div unit via an internal busy counter. Sits beside the pipeline registers and drives their enable/reset inputs.

## Interface
Parameters:
- MULT_CYCLES, 5, busy cycles after mult/multu leaves E
- DIV_CYCLES, 10, busy cycles after div/divu leaves E

Ports:
- clk  in  1  system clock, all state on posedge
- reset  in  1  synchronous, active-high
- instr_D  in  32  instruction in IF/ID
- instr_E  in  32  instruction in ID/EX
- instr_M  in  32  instruction in EX/M
- stall_F  out  1  hold PC
- stall_D  out  1  hold IF/ID
- flush_E  out  1  load nop (0) into ID/EX next edge
- md_busy  out  1  mult/div unit computing

## Operation
- Decode per stage: op=[31:26], rs=[25:21], rt=[20:16], rd=[15:11], funct=[5:0].
- Write register (wreg):
  - R-type addu/subu/and/or/slt/sll/srl/mfhi/mflo/jalr → rd.
  - addiu/slti/ori/lui/lw → rt.
  - jal → 31.
  - Everything else → 0.
- Register $0 never causes a hazard.
- Load-use: E is lw (op 0x23), and wreg_E is non-zero and equals a register D reads (rs; rt for R-type, beq, bne, sw) → stall.
- Branch hazard: D is beq (0x04), bne (0x05), jr or jalr.
  - Stall if wreg_E matches its rs/rt.
  - Also stall if M is lw and wreg_M matches.
- MD hazard: D is mult/multu/div/divu/mfhi/mflo/mthi/mtlo, and either md_busy=1 or E holds mult/div (start pending) → stall.
- stall = OR of the three conditions; stall_F = stall_D = flush_E = stall.
- Busy FSM, states IDLE and BUSY, 4-bit down-counter cnt:
  - IDLE, and E holds mult/multu (funct 0x18/0x19, op 0) → cnt←MULT_CYCLES, go BUSY.
  - IDLE, and E holds div/divu (0x1A/0x1B) → cnt←DIV_CYCLES, go BUSY.
  - BUSY: cnt←cnt-1 each edge. When cnt=1 at an edge, go IDLE, cnt←0.
  - BUSY, and E holds mult/div (only reachable by illegal stimulus) → restart counter with the new load value.
- md_busy = (state==BUSY), registered.

## Timing
- Stall outputs are combinational from instr_* and the registered state. They are valid in the same cycle the hazard is present.
- mult in E at cycle t:
  - md_busy=1 for cycles t+1..t+5.
  - md_busy=0 at t+6.
  - An mflo held in D is stalled through t+5 and advances at the t+6 edge.
- div: md_busy=1 for t+1..t+10.
- Load-use costs exactly one bubble: the next cycle the lw is in M, so the load-use condition clears.
- Branch after lw costs two bubbles: stall for lw in E, then stall for lw in M.
- While reset=1:
  - stall_F, stall_D and flush_E are forced 0.
  - At the clock edge, state←IDLE, cnt←0, md_busy←0.
- Reset mid-BUSY aborts the count; md_busy=0 the cycle after the reset edge.
- Simultaneous load-use and MD stall produce a single stall (OR); there is no double counting.

## Structure
- Opcode/funct constants (OP_LW, OP_BEQ, OP_BNE, OP_JAL, FN_MULT, FN_DIV, FN_JR, FN_MFLO, …) live in the shared mips_defs include, which the decoder also uses.
- One sub-module, md_busy_counter: FSM plus counter. Inputs: clk, reset, start_mult, start_div. Output: busy.
- Write-register decode is a function inside hazard_stall_ctrl.

## Test plan
- Load-use: instr_E=0x8D280000 (lw $8,0($9)), instr_D=0x010B5021 (addu $10,$8,$11) → stall_F=stall_D=flush_E=1 for one cycle. With instr_D rt=$0 or an unrelated register → 0.
- Branch after lw: instr_D=0x11000003 (beq $8,$0) behind lw $8:
  - lw in E → stall.
  - Next cycle, lw in M → stall.
  - Then clear: 2 bubbles total.
- MD timing: E=0x00850018 (mult $4,$5), D=0x00001012 (mflo $2):
  - stall asserted cycles t..t+5.
  - md_busy high t+1..t+5.
  - Both low at t+6.
- Div: E=0x0085001A → md_busy high exactly 10 cycles. A non-MD instruction in D (addu) is never stalled meanwhile.
- Reset mid-count: assert reset 3 cycles into a div → md_busy=0 after the edge and all stalls 0 during reset. A following mult restarts with a full 5-cycle count.
- $0 immunity: E=addu $0,… and D=beq $0,$0 → no stall.

Source files
------------

// File: rtl/hazard_stall_ctrl_pkg.sv
// Shared MIPS opcode/funct encodings, instruction field layout and busy-FSM state codes
// used by the hazard controller and the instruction decoder.
package hazard_stall_ctrl_pkg;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_JAL   = 6'h03;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_BNE   = 6'h05;
    localparam logic [5:0] OP_ADDIU = 6'h09;
    localparam logic [5:0] OP_SLTI  = 6'h0A;
    localparam logic [5:0] OP_ORI   = 6'h0D;
    localparam logic [5:0] OP_LUI   = 6'h0F;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;

    localparam logic [5:0] FN_SLL   = 6'h00;
    localparam logic [5:0] FN_SRL   = 6'h02;
    localparam logic [5:0] FN_JR    = 6'h08;
    localparam logic [5:0] FN_JALR  = 6'h09;
    localparam logic [5:0] FN_MFHI  = 6'h10;
    localparam logic [5:0] FN_MTHI  = 6'h11;
    localparam logic [5:0] FN_MFLO  = 6'h12;
    localparam logic [5:0] FN_MTLO  = 6'h13;
    localparam logic [5:0] FN_MULT  = 6'h18;
    localparam logic [5:0] FN_MULTU = 6'h19;
    localparam logic [5:0] FN_DIV   = 6'h1A;
    localparam logic [5:0] FN_DIVU  = 6'h1B;
    localparam logic [5:0] FN_ADDU  = 6'h21;
    localparam logic [5:0] FN_SUBU  = 6'h23;
    localparam logic [5:0] FN_AND   = 6'h24;
    localparam logic [5:0] FN_OR    = 6'h25;
    localparam logic [5:0] FN_SLT   = 6'h2A;

    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_BUSY = 1'b1;

    typedef struct packed {
        logic [5:0] op;
        logic [4:0] rs;
        logic [4:0] rt;
        logic [4:0] rd;
        logic [4:0] shamt;
        logic [5:0] funct;
    } instr_t;

    // Any instruction that touches HI/LO and therefore must wait for the mult/div unit.
    function automatic logic uses_hilo(input logic [5:0] op, input logic [5:0] funct);
        return (op == OP_RTYPE) &&
               (funct == FN_MULT || funct == FN_MULTU || funct == FN_DIV  || funct == FN_DIVU ||
                funct == FN_MFHI || funct == FN_MFLO  || funct == FN_MTHI || funct == FN_MTLO);
    endfunction

endpackage

// File: rtl/hazard_stall_ctrl_md_busy_counter.sv
// Busy tracker for the multi-cycle mult/div unit: a two-state FSM with a 4-bit down-counter
// loaded when a mult or div leaves the E stage.
module md_busy_counter
    import hazard_stall_ctrl_pkg::*;
#(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic clk,
    input  logic reset,
    input  logic start_mult,
    input  logic start_div,
    output logic busy
);

    localparam logic [3:0] MULT_LOAD = 4'(MULT_CYCLES);
    localparam logic [3:0] DIV_LOAD  = 4'(DIV_CYCLES);

    logic [0:0] state_reg, state_next;
    logic [3:0] cnt_reg, cnt_next;

    // A start while already busy simply reloads the counter.
    always_comb begin
        state_next = state_reg;
        cnt_next   = cnt_reg;
        if (start_mult) begin
            state_next = ST_BUSY;
            cnt_next   = MULT_LOAD;
        end else if (start_div) begin
            state_next = ST_BUSY;
            cnt_next   = DIV_LOAD;
        end else if (state_reg == ST_BUSY) begin
            if (cnt_reg == 4'd1) begin
                state_next = ST_IDLE;
                cnt_next   = 4'd0;
            end else begin
                cnt_next = cnt_reg - 4'd1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg <= ST_IDLE;
            cnt_reg   <= 4'd0;
        end else begin
            state_reg <= state_next;
            cnt_reg   <= cnt_next;
        end
    end

    assign busy = (state_reg == ST_BUSY);

endmodule

// File: rtl/hazard_stall_ctrl.sv
// Pipeline hazard/stall controller: detects load-use, branch-operand and mult/div hazards
// from the D/E/M instructions and drives PC/IF-ID hold and ID-EX flush.
module hazard_stall_ctrl
    import hazard_stall_ctrl_pkg::*;
#(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] instr_D,
    input  logic [31:0] instr_E,
    input  logic [31:0] instr_M,
    output logic        stall_F,
    output logic        stall_D,
    output logic        flush_E,
    output logic        md_busy
);

    function automatic logic [4:0] wreg_of(input logic [5:0] op, input logic [4:0] rt,
                                           input logic [4:0] rd, input logic [5:0] funct);
        logic [4:0] r;
        r = 5'd0;
        case (op)
            OP_RTYPE: begin
                case (funct)
                    FN_ADDU, FN_SUBU, FN_AND, FN_OR, FN_SLT, FN_SLL, FN_SRL,
                    FN_MFHI, FN_MFLO, FN_JALR: r = rd;
                    default: r = 5'd0;
                endcase
            end
            OP_ADDIU, OP_SLTI, OP_ORI, OP_LUI, OP_LW: r = rt;
            OP_JAL:  r = 5'd31;
            default: r = 5'd0;
        endcase
        return r;
    endfunction

    instr_t d_i, e_i, m_i;
    assign d_i = instr_t'(instr_D);
    assign e_i = instr_t'(instr_E);
    assign m_i = instr_t'(instr_M);

    logic unused_bits;
    assign unused_bits = ^{d_i.rd, d_i.shamt, e_i.rs, e_i.shamt, m_i.rs, m_i.shamt};

    logic [4:0] wreg_E, wreg_M;
    assign wreg_E = wreg_of(e_i.op, e_i.rt, e_i.rd, e_i.funct);
    assign wreg_M = wreg_of(m_i.op, m_i.rt, m_i.rd, m_i.funct);

    logic d_reads_rt, d_is_branch, d_uses_hilo;
    assign d_reads_rt  = (d_i.op == OP_RTYPE) || (d_i.op == OP_BEQ) ||
                         (d_i.op == OP_BNE)   || (d_i.op == OP_SW);
    assign d_is_branch = (d_i.op == OP_BEQ) || (d_i.op == OP_BNE) ||
                         ((d_i.op == OP_RTYPE) && (d_i.funct == FN_JR || d_i.funct == FN_JALR));
    assign d_uses_hilo = uses_hilo(d_i.op, d_i.funct);

    // $0 is hard-wired, so a zero write register never matches anything.
    logic match_E, match_M;
    assign match_E = (wreg_E != 5'd0) &&
                     ((wreg_E == d_i.rs) || (d_reads_rt && (wreg_E == d_i.rt)));
    assign match_M = (wreg_M != 5'd0) &&
                     ((wreg_M == d_i.rs) || (d_reads_rt && (wreg_M == d_i.rt)));

    logic start_mult, start_div;
    assign start_mult = (e_i.op == OP_RTYPE) && (e_i.funct == FN_MULT || e_i.funct == FN_MULTU);
    assign start_div  = (e_i.op == OP_RTYPE) && (e_i.funct == FN_DIV  || e_i.funct == FN_DIVU);

    md_busy_counter #(
        .MULT_CYCLES (MULT_CYCLES),
        .DIV_CYCLES  (DIV_CYCLES)
    ) u_md_busy_counter (
        .clk        (clk),
        .reset      (reset),
        .start_mult (start_mult),
        .start_div  (start_div),
        .busy       (md_busy)
    );

    logic load_use, branch_haz, md_haz, stall;
    assign load_use   = (e_i.op == OP_LW) && match_E;
    // Branches resolve in D, so any in-flight producer in E, or a load still in M, blocks them.
    assign branch_haz = d_is_branch && (match_E || ((m_i.op == OP_LW) && match_M));
    assign md_haz     = d_uses_hilo && (md_busy || start_mult || start_div);
    assign stall      = !reset && (load_use || branch_haz || md_haz);

    assign stall_F = stall;
    assign stall_D = stall;
    assign flush_E = stall;

endmodule

// File: tb/tb_hazard_stall_ctrl.sv
// Directed bench for hazard_stall_ctrl: a table of single-cycle hazard vectors plus
// hand-written multi-cycle sequences for load/branch bubbles, mult/div timing and reset.
module tb_hazard_stall_ctrl;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] instr_D, instr_E, instr_M;
    logic        stall_F, stall_D, flush_E, md_busy;

    int errors = 0;
    int checks = 0;

    hazard_stall_ctrl #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
        .clk     (clk),
        .reset   (reset),
        .instr_D (instr_D),
        .instr_E (instr_E),
        .instr_M (instr_M),
        .stall_F (stall_F),
        .stall_D (stall_D),
        .flush_E (flush_E),
        .md_busy (md_busy)
    );

    always #5 clk = ~clk;

    localparam logic [31:0] LW8     = 32'h8D280000; // lw   $8,0($9)
    localparam logic [31:0] ADDU_8  = 32'h010B5021; // addu $10,$8,$11
    localparam logic [31:0] ADDU_W8 = 32'h012B4021; // addu $8,$9,$11
    localparam logic [31:0] BEQ8    = 32'h11000003; // beq  $8,$0,3
    localparam logic [31:0] MULT45  = 32'h00850018; // mult $4,$5
    localparam logic [31:0] DIV45   = 32'h0085001A; // div  $4,$5
    localparam logic [31:0] MFLO2   = 32'h00001012; // mflo $2
    localparam logic [31:0] MULT89  = 32'h01090018; // mult $8,$9

    typedef struct {
        logic [31:0] d;
        logic [31:0] e;
        logic [31:0] m;
        logic        stall;
        string       name;
    } vec_t;

    vec_t vecs[18];

    task automatic cyc(input logic [31:0] d, input logic [31:0] e, input logic [31:0] m,
                       input logic rst, input logic exp_stall, input logic exp_busy,
                       input string name);
        instr_D = d;
        instr_E = e;
        instr_M = m;
        reset   = rst;
        @(negedge clk);
        checks++;
        if ({stall_F, stall_D, flush_E} !== {3{exp_stall}}) begin
            errors++;
            $display("FAIL %s stall: got F/D/E=%b%b%b expected %b", name,
                     stall_F, stall_D, flush_E, exp_stall);
        end
        checks++;
        if (md_busy !== exp_busy) begin
            errors++;
            $display("FAIL %s md_busy: got %b expected %b", name, md_busy, exp_busy);
        end
        $display("%-16s D=%h E=%h M=%h rst=%b stall=%b busy=%b", name, d, e, m, rst,
                 stall_F, md_busy);
        @(posedge clk);
        #1;
    endtask

    initial begin
        vecs[0]  = '{32'h010B5021, LW8, 32'h0, 1'b1, "lu_rs"};
        vecs[1]  = '{32'h01205021, LW8, 32'h0, 1'b0, "lu_unrel_rt0"};
        vecs[2]  = '{32'h01685021, LW8, 32'h0, 1'b1, "lu_rt"};
        vecs[3]  = '{32'h350A0001, LW8, 32'h0, 1'b1, "lu_ori_rs"};
        vecs[4]  = '{32'h35480001, LW8, 32'h0, 1'b0, "lu_ori_rt_nr"};
        vecs[5]  = '{32'hAD480000, LW8, 32'h0, 1'b1, "lu_sw_rt"};
        vecs[6]  = '{ADDU_8, ADDU_W8, 32'h0, 1'b0, "alu_fwd_ok"};
        vecs[7]  = '{BEQ8, ADDU_W8, 32'h0, 1'b1, "br_alu_in_e"};
        vecs[8]  = '{BEQ8, 32'h0, LW8, 1'b1, "br_lw_in_m"};
        vecs[9]  = '{BEQ8, 32'h0, ADDU_W8, 1'b0, "br_alu_in_m"};
        vecs[10] = '{32'h01000008, 32'h25280004, 32'h0, 1'b1, "jr_addiu_e"};
        vecs[11] = '{32'h0100F809, 32'h0, LW8, 1'b1, "jalr_lw_m"};
        vecs[12] = '{32'h10000003, 32'h01090021, 32'h0, 1'b0, "zero_beq"};
        vecs[13] = '{32'h00005021, 32'h8D200000, 32'h0, 1'b0, "zero_lw"};
        vecs[14] = '{MFLO2, 32'h0, 32'h0, 1'b0, "mflo_idle"};
        vecs[15] = '{32'h03E00008, 32'h0C000010, 32'h0, 1'b1, "jr31_jal_e"};
        vecs[16] = '{32'h152A0005, 32'h3C0A1234, 32'h0, 1'b1, "bne_lui_e"};
        vecs[17] = '{BEQ8, 32'hAD280000, 32'h0, 1'b0, "br_sw_e"};

        reset   = 1'b1;
        instr_D = 32'h0;
        instr_E = 32'h0;
        instr_M = 32'h0;
        @(posedge clk);
        #1;
        cyc(ADDU_8, LW8, 32'h0, 1'b1, 1'b0, 1'b0, "reset_hold");
        cyc(ADDU_8, LW8, 32'h0, 1'b0, 1'b1, 1'b0, "after_reset");

        foreach (vecs[i])
            cyc(vecs[i].d, vecs[i].e, vecs[i].m, 1'b0, vecs[i].stall, 1'b0, vecs[i].name);

        // Load-use: exactly one bubble.
        cyc(ADDU_8, LW8, 32'h0, 1'b0, 1'b1, 1'b0, "lu_seq_e");
        cyc(ADDU_8, 32'h0, LW8, 1'b0, 1'b0, 1'b0, "lu_seq_m");

        // Branch behind lw: two bubbles.
        cyc(BEQ8, LW8, 32'h0, 1'b0, 1'b1, 1'b0, "brlw_seq_e");
        cyc(BEQ8, 32'h0, LW8, 1'b0, 1'b1, 1'b0, "brlw_seq_m");
        cyc(BEQ8, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0, "brlw_seq_clr");

        // mult in E at t, mflo held in D until t+6.
        cyc(MFLO2, MULT45, 32'h0, 1'b0, 1'b1, 1'b0, "mult_t0");
        for (int k = 1; k <= 5; k++) begin
            if (k == 2)
                cyc(MULT89, LW8, 32'h0, 1'b0, 1'b1, 1'b1, "mult_and_lu");
            else
                cyc(MFLO2, 32'h0, 32'h0, 1'b0, 1'b1, 1'b1, "mult_busy");
        end
        cyc(MFLO2, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0, "mult_t6");

        // div: ten busy cycles, non-MD instruction never stalled.
        cyc(ADDU_8, DIV45, 32'h0, 1'b0, 1'b0, 1'b0, "div_t0");
        for (int k = 1; k <= 10; k++)
            cyc(ADDU_8, 32'h0, 32'h0, 1'b0, 1'b0, 1'b1, "div_busy");
        cyc(ADDU_8, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0, "div_done");

        // Reset three cycles into a div aborts the count.
        cyc(MFLO2, DIV45, 32'h0, 1'b0, 1'b1, 1'b0, "rdiv_t0");
        cyc(MFLO2, 32'h0, 32'h0, 1'b0, 1'b1, 1'b1, "rdiv_t1");
        cyc(MFLO2, 32'h0, 32'h0, 1'b0, 1'b1, 1'b1, "rdiv_t2");
        cyc(MFLO2, LW8, 32'h0, 1'b1, 1'b0, 1'b1, "rdiv_reset");
        cyc(MFLO2, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0, "rdiv_after");

        // A following mult gets a full five-cycle count.
        cyc(ADDU_8, MULT45, 32'h0, 1'b0, 1'b0, 1'b0, "remult_t0");
        for (int k = 1; k <= 5; k++)
            cyc(ADDU_8, 32'h0, 32'h0, 1'b0, 1'b0, 1'b1, "remult_busy");
        cyc(ADDU_8, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0, "remult_t6");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
